// File: rtl/coffee_disp_pkg.sv
// coffee_disp_pkg: character codes, message texts and shared constants for the front-panel display
package coffee_disp_pkg;
  typedef logic [4:0] char_t;
  localparam char_t CH_0 = 5'd0, CH_1 = 5'd1, CH_2 = 5'd2, CH_3 = 5'd3, CH_4 = 5'd4;
  localparam char_t CH_5 = 5'd5, CH_6 = 5'd6, CH_7 = 5'd7, CH_8 = 5'd8, CH_9 = 5'd9;
  localparam char_t CH_C = 5'd10, CH_E = 5'd11, CH_L = 5'd12, CH_P = 5'd13, CH_R = 5'd14;
  localparam char_t CH_S = 5'd15, CH_N = 5'd16, CH_D = 5'd17, CH_I = 5'd18, CH_BLANK = 5'd31;
  localparam int MAX_MSGS = 16;
  localparam int MAX_DIGITS = 8;
  localparam int MSG_IDLE = 8;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam char_t MSG_TEXT [MAX_MSGS][MAX_DIGITS] = '{
    '{CH_C, CH_E, CH_0, CH_1, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_C, CH_L, CH_0, CH_2, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_C, CH_C, CH_0, CH_5, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_C, CH_P, CH_1, CH_0, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_E, CH_R, CH_S, CH_R, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_E, CH_R, CH_S, CH_P, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_E, CH_R, CH_S, CH_N, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_E, CH_R, CH_D, CH_I, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
    '{default: CH_BLANK}, '{default: CH_BLANK}, '{default: CH_BLANK}, '{default: CH_BLANK},
    '{default: CH_BLANK}, '{default: CH_BLANK}, '{default: CH_BLANK}, '{default: CH_BLANK}
  };
endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: character code to {g,f,e,d,c,b,a} segment pattern, unknown codes are blank
module seg_glyph_rom
  import coffee_disp_pkg::*;
(
  input  char_t      ch,
  output logic [6:0] seg
);
  always_comb begin
    case (ch)
      CH_0: seg = 7'h3F;
      CH_1: seg = 7'h06;
      CH_2: seg = 7'h5B;
      CH_3: seg = 7'h4F;
      CH_4: seg = 7'h66;
      CH_5: seg = 7'h6D;
      CH_6: seg = 7'h7D;
      CH_7: seg = 7'h07;
      CH_8: seg = 7'h7F;
      CH_9: seg = 7'h6F;
      CH_C: seg = 7'h39;
      CH_E: seg = 7'h79;
      CH_L: seg = 7'h38;
      CH_P: seg = 7'h73;
      CH_R: seg = 7'h50;
      CH_S: seg = 7'h6D;
      CH_N: seg = 7'h54;
      CH_D: seg = 7'h5E;
      CH_I: seg = 7'h30;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-segment scan with priority messages, frame-synchronous
// switching, error blinking and a blank gap at the start of every digit slot
module display_scan_ctrl
  import coffee_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int NUM_MSGS     = MSG_IDLE,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 64,
  parameter logic [NUM_MSGS-1:0] BLINK_MASK = NUM_MSGS'(8'hF0),
  localparam int AW = $clog2(NUM_MSGS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_MSGS-1:0]   msg_req,
  input  logic                  dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] dig,
  output logic [AW-1:0]         active_msg,
  output logic                  frame_tick
);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(PRESCALE);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [AW-1:0] IDLE = AW'(NUM_MSGS);
  logic [PW-1:0] pre;
  logic [DW-1:0] idx;
  logic [BW-1:0] bcnt;
  logic          phase_on;
  logic [AW-1:0] sel;
  logic          tc, wrap, lit, dark, idle;
  logic [15:0]   mask;
  char_t         ch;
  logic [6:0]    glyph;
  always_comb begin
    sel = IDLE;
    for (int i = 0; i < NUM_MSGS; i++) sel = msg_req[i] ? AW'(i) : sel;
  end
  assign tc   = pre == PW'(PRESCALE - 1);
  assign wrap = tc && idx == DW'(NUM_DIGITS - 1);
  assign lit  = pre >= PW'(BLANK_CYCLES);
  assign idle = active_msg == IDLE;
  assign mask = 16'(BLINK_MASK);
  assign dark = !idle && mask[4'(active_msg)] && !phase_on;
  assign ch   = idle ? CH_BLANK : MSG_TEXT[4'(active_msg)][3'(idx)];
  seg_glyph_rom u_rom (.ch(ch), .seg(glyph));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      idx        <= '0;
      bcnt       <= '0;
      phase_on   <= 1'b1;
      active_msg <= IDLE;
      frame_tick <= 1'b0;
      dig        <= '0;
      seg        <= SEG_BLANK;
      dp         <= 1'b0;
    end else begin
      pre        <= tc ? '0 : pre + 1'b1;
      frame_tick <= wrap;
      if (tc) idx <= idx == DW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      // a message change restarts the blink so a new error is visible at once
      if (wrap) begin
        if (sel != active_msg) begin
          active_msg <= sel;
          bcnt       <= '0;
          phase_on   <= 1'b1;
        end else if (bcnt == BW'(BLINK_FRAMES - 1)) begin
          bcnt     <= '0;
          phase_on <= ~phase_on;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
      dig <= lit ? NUM_DIGITS'(1) << idx : '0;
      seg <= lit && !dark ? glyph : SEG_BLANK;
      dp  <= lit && !dark && (dp_in || idle);
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: frame-by-frame scoreboard check of scan timing, arbitration and blinking
module tb_display_scan_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, dp_in = 1'b0;
  logic [7:0] msg_req = '0;
  logic [6:0] seg;
  logic       dp, frame_tick;
  logic [3:0] dig, active_msg;
  always #5 clk = ~clk;
  display_scan_ctrl #(
    .NUM_DIGITS(4), .NUM_MSGS(8), .PRESCALE(4), .BLANK_CYCLES(1),
    .BLINK_FRAMES(2), .BLINK_MASK(8'hF0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .msg_req(msg_req), .dp_in(dp_in), .seg(seg), .dp(dp),
    .dig(dig), .active_msg(active_msg), .frame_tick(frame_tick)
  );
  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] msg;
  } exp_t;
  exp_t sbq[$];
  int n_tests = 0, n_fail = 0;
  int cur_msg = 8, nfr = 0;
  localparam logic [7:0] MASK = 8'hF0;
  localparam logic [6:0] GL [9][4] = '{
    '{7'h39, 7'h79, 7'h3F, 7'h06}, '{7'h39, 7'h38, 7'h3F, 7'h5B},
    '{7'h39, 7'h39, 7'h3F, 7'h6D}, '{7'h39, 7'h73, 7'h06, 7'h3F},
    '{7'h79, 7'h50, 7'h6D, 7'h50}, '{7'h79, 7'h50, 7'h6D, 7'h73},
    '{7'h79, 7'h50, 7'h6D, 7'h54}, '{7'h79, 7'h50, 7'h5E, 7'h30},
    '{7'h00, 7'h00, 7'h00, 7'h00}
  };
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int prio(input logic [7:0] r);
    int p = 8;
    for (int i = 0; i < 8; i++) if (r[i]) p = i;
    return p;
  endfunction
  // expected frame from the message shown and how many frames it has been up
  task automatic push_frame(input logic dpv);
    logic off;
    off = cur_msg < 8 && MASK[cur_msg] && ((nfr / 2) % 2 == 1);
    for (int d = 0; d < 4; d++)
      sbq.push_back('{dig: 4'(1 << d), seg: off ? 7'h00 : GL[cur_msg][d],
                      dp: !off && (dpv || cur_msg == 8), msg: 4'(cur_msg)});
  endtask
  task automatic run_frame(input logic [7:0] req, input logic [7:0] glitch, input logic dpv);
    exp_t e;
    int p;
    for (int d = 0; d < 4; d++) begin
      if (sbq.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
        e = '0;
      end else e = sbq.pop_front();
      @(negedge clk);
      check("gap", {dig, seg, dp}, 32'd0);
      check("active_msg", active_msg, e.msg);
      check("tick_gap", frame_tick, 32'd0);
      if (d == 0 && glitch != 0) msg_req = glitch;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("slot", {dig, seg, dp}, {e.dig, e.seg, e.dp});
        check("frame_tick", frame_tick, (d == 3 && c == 2) ? 32'd1 : 32'd0);
      end
      if (d == 1) begin
        msg_req = req;
        p = prio(req);
        if (p != cur_msg) begin
          cur_msg = p;
          nfr = 0;
        end else nfr++;
        push_frame(dpv);
      end
    end
    dp_in = dpv;
  endtask
  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    check("rst_outs", {dig, seg, dp, frame_tick}, 32'd0);
    check("rst_msg", active_msg, 32'd8);
    rst_n = 1'b1;
    push_frame(1'b0);
    repeat (2) run_frame(8'h00, 8'h00, 1'b0);
    run_frame(8'h00, 8'h10, 1'b0);
    run_frame(8'h04, 8'h00, 1'b0);
    run_frame(8'h05, 8'h00, 1'b1);
    repeat (7) run_frame(8'h05, 8'h00, 1'b0);
    repeat (4) run_frame(8'h44, 8'h00, 1'b0);
    repeat (5) run_frame(8'h84, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    e = sbq.pop_front();
    check("pre_rst_lit", {dig, seg, dp}, {e.dig, e.seg, e.dp});
    rst_n = 1'b0;
    #1;
    check("rst_async", {dig, seg, dp, frame_tick}, 32'd0);
    check("rst_async_msg", active_msg, 32'd8);
    msg_req = '0;
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cur_msg = 8;
    nfr = 0;
    push_frame(1'b0);
    repeat (2) run_frame(8'h00, 8'h00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
